// File: rtl/als_spi_pkg.sv
// als_spi_pkg: ADC frame layout shared by the responder and the light-sensor reader.
package als_spi_pkg;
    localparam int LEAD_ZEROS  = 3;
    localparam int DATA_BITS   = 8;
    localparam int FRAME_BITS  = 16;
    localparam int TRAIL_ZEROS = FRAME_BITS - LEAD_ZEROS - DATA_BITS;

    typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchronizer followed by a registered edge detector.
module sync_edge_det #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk_10Mhz,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;

    always_ff @(posedge clk_10Mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync  <= {STAGES{INIT}};
            level <= INIT;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync  <= {sync[STAGES-2:0], din};
            level <= sync[STAGES-1];
            rise  <= sync[STAGES-1] & ~level;
            fall  <= ~sync[STAGES-1] & level;
        end
    end
endmodule

// File: rtl/als_spi_responder.sv
// als_spi_responder: emulates the ambient-light-sensor ADC, serving a 16-bit
// frame {3 zeros, sample, 5 zeros} MSB first; sdata changes on sclk falling edges.
module als_spi_responder
    import als_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_10Mhz,
    input  logic                 reset_n,
    input  logic                 cs_n,
    input  logic                 sclk,
    input  logic [DATA_BITS-1:0] sample_value,
    output logic                 sdata,
    output logic                 sdata_oe,
    output logic                 frame_done,
    output logic                 frame_abort,
    output logic [7:0]           frame_count
);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int BIT_W = $clog2(FRAME_BITS);

    logic cs_lvl, cs_rise, cs_fall, sclk_lvl, sclk_rise, sclk_fall;
    logic start, s_rise, s_fall;
    state_t state, state_n;
    logic [FRAME_BITS-1:0] shift_reg, shift_n;
    logic [CNT_W-1:0] rise_cnt, rise_n;
    logic [BIT_W-1:0] bit_cnt, bit_n;
    logic sdata_n, oe_n, done_n, abort_n;
    logic [7:0] count_n;

    sync_edge_det #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
        .clk_10Mhz(clk_10Mhz), .reset_n(reset_n), .din(cs_n),
        .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk (
        .clk_10Mhz(clk_10Mhz), .reset_n(reset_n), .din(sclk),
        .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    // Edge pulses qualified by the settled level they lead to.
    assign start  = cs_fall & ~cs_lvl;
    assign s_rise = sclk_rise & sclk_lvl;
    assign s_fall = sclk_fall & ~sclk_lvl;

    always_comb begin
        state_n = state;
        shift_n = shift_reg;
        rise_n  = rise_cnt;
        bit_n   = bit_cnt;
        oe_n    = sdata_oe;
        done_n  = 1'b0;
        abort_n = 1'b0;
        count_n = frame_count;
        case (state)
            IDLE: if (start) begin
                state_n = SHIFT;
                shift_n = FRAME_BITS'(sample_value) << TRAIL_ZEROS;
                rise_n  = '0;
                bit_n   = '0;
                oe_n    = 1'b1;
            end
            SHIFT: if (cs_rise) begin
                state_n = IDLE;
                abort_n = 1'b1;
                oe_n    = 1'b0;
            end else if (s_rise) begin
                rise_n  = rise_cnt + 1'b1;
                state_n = (rise_n == CNT_W'(FRAME_BITS)) ? TAIL : SHIFT;
            end else if (s_fall) begin
                shift_n = shift_reg << 1;
                bit_n   = bit_cnt + 1'b1;
            end
            TAIL: if (cs_rise) begin
                state_n = IDLE;
                done_n  = 1'b1;
                count_n = frame_count + 1'b1;
                oe_n    = 1'b0;
            end
            default: state_n = IDLE;
        endcase
        sdata_n = (state_n == SHIFT) && shift_n[FRAME_BITS-1];
    end

    always_ff @(posedge clk_10Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            shift_reg   <= '0;
            rise_cnt    <= '0;
            bit_cnt     <= '0;
            sdata       <= 1'b0;
            sdata_oe    <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_n;
            shift_reg   <= shift_n;
            rise_cnt    <= rise_n;
            bit_cnt     <= bit_n;
            sdata       <= sdata_n;
            sdata_oe    <= oe_n;
            frame_done  <= done_n;
            frame_abort <= abort_n;
            frame_count <= count_n;
        end
    end
endmodule
